pin_entry_ctrl: RTL and testbench

PIN_ENTRY_CTRL -- requirements
Module: pin_entry_ctrl

---
 rtl/pin_entry_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pin_entry_ctrl.sv
// PIN entry controller for a card reader keypad: collects four BCD digits,
// checks them against the expected PIN, and grants the session or retains the card.
module pin_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_TRIES      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] correct_pin,
  output logic        pin_ok,
  output logic        pin_fail,
  output logic        pin_granted,
  output logic        card_locked,
  output logic        timeout,
  output logic [2:0]  digit_count,
  output logic [1:0]  try_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COLLECT = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] GRANTED = 3'd3;
  localparam logic [2:0] LOCKED  = 3'd4;

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [2:0]    state_reg, state_next;
  logic [15:0]   buffer_reg, buffer_next;
  logic [2:0]    digit_count_reg, digit_count_next;
  logic [1:0]    try_count_reg, try_count_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          pin_ok_next, pin_fail_next, timeout_next;

  logic key_accepted;
  logic key_is_digit;

  // Reserved codes never count as activity, so they neither act nor reset the timer.
  assign key_accepted = key_valid && (key_code <= 4'hC);
  assign key_is_digit = key_code <= 4'd9;

  always_comb begin
    state_next       = state_reg;
    buffer_next      = buffer_reg;
    digit_count_next = digit_count_reg;
    try_count_next   = try_count_reg;
    timer_next       = timer_reg;
    pin_ok_next      = 1'b0;
    pin_fail_next    = 1'b0;
    timeout_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (card_in) begin
          state_next       = COLLECT;
          buffer_next      = 16'h0000;
          digit_count_next = 3'd0;
          try_count_next   = 2'd0;
          timer_next       = '0;
        end
      end

      COLLECT: begin
        // Card removal outranks both key activity and timer expiry.
        if (!card_in) begin
          state_next       = IDLE;
          buffer_next      = 16'h0000;
          digit_count_next = 3'd0;
          timer_next       = '0;
        end else if (key_accepted) begin
          timer_next = '0;
          if (key_is_digit) begin
            if (digit_count_reg < 3'd4) begin
              buffer_next      = {buffer_reg[11:0], key_code};
              digit_count_next = digit_count_reg + 3'd1;
            end
          end else if (key_code == 4'hA) begin
            buffer_next      = 16'h0000;
            digit_count_next = 3'd0;
          end else if (key_code == 4'hB) begin
            if (digit_count_reg == 3'd4) begin
              state_next = CHECK;
            end
          end else begin
            state_next       = IDLE;
            buffer_next      = 16'h0000;
            digit_count_next = 3'd0;
          end
        end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_next     = 1'b1;
          state_next       = IDLE;
          buffer_next      = 16'h0000;
          digit_count_next = 3'd0;
          timer_next       = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      CHECK: begin
        if (!card_in) begin
          state_next       = IDLE;
          buffer_next      = 16'h0000;
          digit_count_next = 3'd0;
        end else if (buffer_reg == correct_pin) begin
          pin_ok_next = 1'b1;
          state_next  = GRANTED;
        end else begin
          pin_fail_next  = 1'b1;
          try_count_next = try_count_reg + 2'd1;
          if (32'(try_count_reg) + 32'd1 < 32'(MAX_TRIES)) begin
            state_next       = COLLECT;
            buffer_next      = 16'h0000;
            digit_count_next = 3'd0;
            timer_next       = '0;
          end else begin
            state_next = LOCKED;
          end
        end
      end

      GRANTED: begin
        if (!card_in) begin
          state_next       = IDLE;
          buffer_next      = 16'h0000;
          digit_count_next = 3'd0;
        end
      end

      LOCKED: begin
        state_next = LOCKED;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      buffer_reg      <= 16'h0000;
      digit_count_reg <= 3'd0;
      try_count_reg   <= 2'd0;
      timer_reg       <= '0;
      pin_ok          <= 1'b0;
      pin_fail        <= 1'b0;
      pin_granted     <= 1'b0;
      card_locked     <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      buffer_reg      <= buffer_next;
      digit_count_reg <= digit_count_next;
      try_count_reg   <= try_count_next;
      timer_reg       <= timer_next;
      pin_ok          <= pin_ok_next;
      pin_fail        <= pin_fail_next;
      timeout         <= timeout_next;
      pin_granted     <= (state_next == GRANTED);
      card_locked     <= (state_next == LOCKED);
    end
  end

  assign digit_count = digit_count_reg;
  assign try_count   = try_count_reg;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed bench for pin_entry_ctrl: hand-computed expectations checked with
// immediate assertions, one line per key press.
module tb_pin_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_in;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] correct_pin;
  logic        pin_ok, pin_fail, pin_granted, card_locked, timeout;
  logic [2:0]  digit_count;
  logic [1:0]  try_count;

  int checks = 0;
  int errors = 0;

  pin_entry_ctrl dut (
    .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid),
    .key_code(key_code), .correct_pin(correct_pin), .pin_ok(pin_ok),
    .pin_fail(pin_fail), .pin_granted(pin_granted), .card_locked(card_locked),
    .timeout(timeout), .digit_count(digit_count), .try_count(try_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key presented for exactly one rising edge; returns at the following negedge.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    $display("key %h : digit_count=%0d try_count=%0d ok=%b fail=%b granted=%b locked=%b",
             code, digit_count, try_count, pin_ok, pin_fail, pin_granted, card_locked);
  endtask

  task automatic press4(input logic [15:0] digits);
    for (int i = 3; i >= 0; i--) press(digits[i*4 +: 4]);
  endtask

  initial begin
    logic [4:0] all_out;
    logic       seen_to;

    rst = 1'b1; card_in = 1'b0; key_valid = 1'b0; key_code = 4'h0; correct_pin = 16'h1234;
    #1;
    all_out = {pin_ok, pin_fail, pin_granted, card_locked, timeout};
    chk("reset_outputs", 16'(all_out), 16'h0);
    chk("reset_digit_count", 16'(digit_count), 16'h0);
    chk("reset_try_count", 16'(try_count), 16'h0);
    @(negedge clk); rst = 1'b0;

    // Correct PIN 1234
    card_in = 1'b1;
    @(negedge clk);
    press4(16'h1234);
    chk("t1_dc4", 16'(digit_count), 16'd4);
    press(4'hB);
    chk("t1_ok_not_yet", 16'(pin_ok), 16'h0);
    @(negedge clk);
    chk("t1_pin_ok", 16'(pin_ok), 16'h1);
    chk("t1_granted", 16'(pin_granted), 16'h1);
    @(negedge clk);
    chk("t1_ok_pulse_end", 16'(pin_ok), 16'h0);
    press(4'h5);
    chk("t1_granted_hold", 16'(pin_granted), 16'h1);
    card_in = 1'b0;
    @(negedge clk);
    chk("t1_granted_drop", 16'(pin_granted), 16'h0);

    // Clear key mid-entry, then 5678
    card_in = 1'b1;
    @(negedge clk);
    press(4'h1); press(4'h2);
    chk("t2_dc2", 16'(digit_count), 16'd2);
    press(4'hE);
    chk("t2_reserved_ignored", 16'(digit_count), 16'd2);
    press(4'hA);
    chk("t2_dc0", 16'(digit_count), 16'd0);
    press4(16'h5678);
    press(4'h9);
    chk("t2_dc4_full", 16'(digit_count), 16'd4);
    correct_pin = 16'h5678;
    press(4'hB);
    @(negedge clk);
    chk("t2_pin_ok", 16'(pin_ok), 16'h1);
    card_in = 1'b0;
    @(negedge clk);

    // Short entry then timeout
    card_in = 1'b1;
    @(negedge clk);
    press(4'h1); press(4'h2); press(4'h3); press(4'hB);
    chk("t3_dc3", 16'(digit_count), 16'd3);
    chk("t3_no_fail", 16'(pin_fail), 16'h0);
    seen_to = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (timeout) seen_to = 1'b1;
    end
    chk("t3_no_early_timeout", 16'(seen_to), 16'h0);
    @(negedge clk);
    chk("t3_timeout", 16'(timeout), 16'h1);
    chk("t3_dc_cleared", 16'(digit_count), 16'd0);
    card_in = 1'b0;
    @(negedge clk);
    chk("t3_timeout_pulse_end", 16'(timeout), 16'h0);

    // Key at timer expiry wins over timeout
    card_in = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 15; i++) @(negedge clk);
    key_valid = 1'b1; key_code = 4'h7;
    @(negedge clk);
    key_valid = 1'b0;
    chk("t4_key_wins", 16'(timeout), 16'h0);
    chk("t4_digit_buffered", 16'(digit_count), 16'd1);
    for (int i = 1; i <= 15; i++) @(negedge clk);
    chk("t4_timer_restarted", 16'(timeout), 16'h0);
    @(negedge clk);
    chk("t4_timeout_after_restart", 16'(timeout), 16'h1);
    card_in = 1'b0;
    @(negedge clk);

    // Three wrong entries lock the card
    correct_pin = 16'h1234;
    card_in = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= 3; t++) begin
      press4(16'h9999);
      press(4'hB);
      @(negedge clk);
      chk($sformatf("t5_fail_%0d", t), 16'(pin_fail), 16'h1);
      if (t < 3) chk($sformatf("t5_try_%0d", t), 16'(try_count), 16'(t));
      if (t < 3) chk($sformatf("t5_not_locked_%0d", t), 16'(card_locked), 16'h0);
    end
    chk("t5_locked", 16'(card_locked), 16'h1);
    card_in = 1'b0;
    press(4'h1);
    @(negedge clk);
    chk("t5_lock_held", 16'(card_locked), 16'h1);
    #2 rst = 1'b1;
    #1 chk("t5_lock_async_clear", 16'(card_locked), 16'h0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-entry discards session
    card_in = 1'b1;
    @(negedge clk);
    press(4'h1); press(4'h2);
    #2 rst = 1'b1;
    #1;
    all_out = {pin_ok, pin_fail, pin_granted, card_locked, timeout};
    chk("t6_async_outputs", 16'(all_out), 16'h0);
    chk("t6_async_dc", 16'(digit_count), 16'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    press4(16'h1234);
    press(4'hB);
    @(negedge clk);
    chk("t6_fresh_ok", 16'(pin_ok), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
